uivbuf_ctrl: RTL and testbench

- Multi-channel frame-buffer ring manager for the 4-screen video path.
- Per channel, owns the write-buffer index, advanced on each write frame-start.
- Per channel, latches the read-buffer index on each read frame-start. The read index is always BUF_DELAY frames behind the write index, modulo BUF_LENTH.
- Sits between the per-channel video-in DMA writers and the display-side DMA readers; both consume 8-bit buffer numbers.

---
 rtl/uivbuf_pkg.sv | 29 ++
 rtl/uivbuf_chan.sv | 109 ++++++++++
 rtl/uivbuf_ctrl.sv | 55 +++++
 tb/tb_uivbuf_ctrl.sv | 262 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/uivbuf_pkg.sv
// Shared constants and the write-to-read index mapping for the frame-buffer ring manager.
package uivbuf_pkg;

  // Width of a buffer number on the DMA interfaces.
  localparam int unsigned BUFN_W = 8;
  // Width of the optional statistics counters.
  localparam int unsigned STAT_W = 16;

  // Read index that lags write index w by delay frames on a ring of lenth buffers.
  // The intermediate value is 9 bits wide so that lenth - delay + w cannot wrap early.
  function automatic logic [BUFN_W-1:0] rd_map(input logic [BUFN_W-1:0] w,
                                               input int unsigned       lenth,
                                               input int unsigned       delay);
    logic [BUFN_W:0] w9;
    logic [BUFN_W:0] l9;
    logic [BUFN_W:0] d9;
    logic [BUFN_W:0] r9;
    w9 = {1'b0, w};
    l9 = lenth[BUFN_W:0];
    d9 = delay[BUFN_W:0];
    if (w9 < d9) begin
      r9 = l9 - d9 + w9;
    end else begin
      r9 = w9 - d9;
    end
    return r9[BUFN_W-1:0];
  endfunction

endpackage

// File: rtl/uivbuf_chan.sv
// Single-channel ring state: write index, read latch, valid counter and optional stats.
// Optional statistics are built when UIVBUF_STAT_EN is defined.
module uivbuf_chan
  import uivbuf_pkg::*;
#(
  parameter int unsigned BufLenth = 3,
  parameter int unsigned BufDelay = 1
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              en_i,
  input  logic              wr_fs_i,
  input  logic              rd_fs_i,
  output logic [BUFN_W-1:0] wr_bufn_o,
  output logic [BUFN_W-1:0] rd_bufn_o,
`ifdef UIVBUF_STAT_EN
  output logic [STAT_W-1:0] rpt_cnt_o,
  output logic [STAT_W-1:0] drop_cnt_o,
`endif
  output logic              rd_valid_o
);

  localparam logic [BUFN_W-1:0] WrLast   = BUFN_W'(BufLenth - 1);
  localparam logic [BUFN_W-1:0] DelayCnt = BUFN_W'(BufDelay);

  logic              wr_acc;
  logic              rd_acc;
  logic [BUFN_W-1:0] wr_q, wr_d;
  logic [BUFN_W-1:0] rd_q, rd_d;
  logic [BUFN_W-1:0] rd_new;
  logic [BUFN_W-1:0] cnt_q, cnt_d;

  assign wr_acc = en_i & wr_fs_i;
  assign rd_acc = en_i & rd_fs_i;

  // Next write index, read latch and saturating frame-start count.
  always_comb begin
    wr_d = wr_q;
    if (wr_acc) begin
      wr_d = (wr_q == WrLast) ? '0 : wr_q + BUFN_W'(1);
    end
    // Read maps from the index the write side will hold after this edge.
    rd_new = rd_map(wr_d, BufLenth, BufDelay);
    rd_d   = rd_acc ? rd_new : rd_q;
    cnt_d  = cnt_q;
    if (wr_acc && (cnt_q != '1)) begin
      cnt_d = cnt_q + BUFN_W'(1);
    end
  end

  // Core channel state with synchronous reset.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      wr_q  <= '0;
      rd_q  <= '0;
      cnt_q <= '0;
    end else begin
      wr_q  <= wr_d;
      rd_q  <= rd_d;
      cnt_q <= cnt_d;
    end
  end

  assign wr_bufn_o  = wr_q;
  assign rd_bufn_o  = rd_q;
  assign rd_valid_o = (cnt_q > DelayCnt);

`ifdef UIVBUF_STAT_EN
  // Write advances since the last read latch, saturating at 2 (only ">= 2" matters).
  logic [1:0]        adv_q, adv_d;
  logic [1:0]        adv_inc;
  logic [STAT_W-1:0] rpt_q, rpt_d;
  logic [STAT_W-1:0] drop_q, drop_d;

  // Repeat/drop detection on each accepted read frame-start.
  always_comb begin
    adv_inc = adv_q;
    if (wr_acc && (adv_q != 2'd2)) begin
      adv_inc = adv_q + 2'd1;
    end
    adv_d  = rd_acc ? 2'd0 : adv_inc;
    rpt_d  = rpt_q;
    drop_d = drop_q;
    if (rd_acc && (rd_new == rd_q) && (rpt_q != '1)) begin
      rpt_d = rpt_q + STAT_W'(1);
    end
    if (rd_acc && (adv_inc == 2'd2) && (drop_q != '1)) begin
      drop_d = drop_q + STAT_W'(1);
    end
  end

  // Statistics registers.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      adv_q  <= '0;
      rpt_q  <= '0;
      drop_q <= '0;
    end else begin
      adv_q  <= adv_d;
      rpt_q  <= rpt_d;
      drop_q <= drop_d;
    end
  end

  assign rpt_cnt_o  = rpt_q;
  assign drop_cnt_o = drop_q;
`endif

endmodule

// File: rtl/uivbuf_ctrl.sv
// Multi-channel frame-buffer ring manager: one uivbuf_chan per video channel, packed buses.
// Define UIVBUF_STAT_EN to add the per-channel repeat/drop counters.
module uivbuf_ctrl
  import uivbuf_pkg::*;
#(
  parameter int unsigned CH_NUM    = 4,
  parameter int unsigned BUF_LENTH = 3,
  parameter int unsigned BUF_DELAY = 1
) (
  input  logic                     I_clk,
  input  logic                     I_rst,
  input  logic [CH_NUM-1:0]        I_ch_en,
  input  logic [CH_NUM-1:0]        I_wr_fs,
  input  logic [CH_NUM-1:0]        I_rd_fs,
  output logic [CH_NUM*BUFN_W-1:0] O_wr_bufn,
  output logic [CH_NUM*BUFN_W-1:0] O_rd_bufn,
`ifdef UIVBUF_STAT_EN
  output logic [CH_NUM*STAT_W-1:0] O_rpt_cnt,
  output logic [CH_NUM*STAT_W-1:0] O_drop_cnt,
`endif
  output logic [CH_NUM-1:0]        O_rd_valid
);

  // Reject unsupported configurations at elaboration.
  if ((CH_NUM < 1) || (CH_NUM > 8)) begin : g_bad_ch_num
    $error("uivbuf_ctrl: CH_NUM must be 1..8");
  end
  if ((BUF_LENTH < 2) || (BUF_LENTH > 255)) begin : g_bad_buf_lenth
    $error("uivbuf_ctrl: BUF_LENTH must be 2..255");
  end
  if (BUF_DELAY > BUF_LENTH - 1) begin : g_bad_buf_delay
    $error("uivbuf_ctrl: BUF_DELAY must be 0..BUF_LENTH-1");
  end

  for (genvar k = 0; k < CH_NUM; k++) begin : g_chan
    uivbuf_chan #(
      .BufLenth (BUF_LENTH),
      .BufDelay (BUF_DELAY)
    ) u_chan (
      .clk_i      (I_clk),
      .rst_i      (I_rst),
      .en_i       (I_ch_en[k]),
      .wr_fs_i    (I_wr_fs[k]),
      .rd_fs_i    (I_rd_fs[k]),
      .wr_bufn_o  (O_wr_bufn[k*BUFN_W +: BUFN_W]),
      .rd_bufn_o  (O_rd_bufn[k*BUFN_W +: BUFN_W]),
`ifdef UIVBUF_STAT_EN
      .rpt_cnt_o  (O_rpt_cnt[k*STAT_W +: STAT_W]),
      .drop_cnt_o (O_drop_cnt[k*STAT_W +: STAT_W]),
`endif
      .rd_valid_o (O_rd_valid[k])
    );
  end

endmodule

// File: tb/tb_uivbuf_ctrl.sv
// Self-checking bench for uivbuf_ctrl: directed scenarios plus randomized traffic
// against a modular-arithmetic reference model.
module tb_uivbuf_ctrl;

  localparam int CH  = 4;
  localparam int L   = 3;
  localparam int D   = 1;
  localparam int CH2 = 2;
  localparam int L2  = 4;
  localparam int D2  = 2;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic            rst = 1'b1;
  logic [CH-1:0]   en = '0, wr_fs = '0, rd_fs = '0;
  logic [CH*8-1:0] wr_bufn, rd_bufn;
  logic [CH-1:0]   rd_valid;

  logic [CH2-1:0]   en2 = '0, wr2 = '0, rd2 = '0;
  logic [CH2*8-1:0] wr_bufn2, rd_bufn2;
  logic [CH2-1:0]   rd_valid2;

`ifdef UIVBUF_STAT_EN
  logic [CH*16-1:0]  rpt_cnt, drop_cnt;
  logic [CH2*16-1:0] rpt_cnt2, drop_cnt2;
`endif

  uivbuf_ctrl #(.CH_NUM(CH), .BUF_LENTH(L), .BUF_DELAY(D)) dut (
    .I_clk      (clk),
    .I_rst      (rst),
    .I_ch_en    (en),
    .I_wr_fs    (wr_fs),
    .I_rd_fs    (rd_fs),
    .O_wr_bufn  (wr_bufn),
    .O_rd_bufn  (rd_bufn),
`ifdef UIVBUF_STAT_EN
    .O_rpt_cnt  (rpt_cnt),
    .O_drop_cnt (drop_cnt),
`endif
    .O_rd_valid (rd_valid)
  );

  uivbuf_ctrl #(.CH_NUM(CH2), .BUF_LENTH(L2), .BUF_DELAY(D2)) dut2 (
    .I_clk      (clk),
    .I_rst      (rst),
    .I_ch_en    (en2),
    .I_wr_fs    (wr2),
    .I_rd_fs    (rd2),
    .O_wr_bufn  (wr_bufn2),
    .O_rd_bufn  (rd_bufn2),
`ifdef UIVBUF_STAT_EN
    .O_rpt_cnt  (rpt_cnt2),
    .O_drop_cnt (drop_cnt2),
`endif
    .O_rd_valid (rd_valid2)
  );

  int pass_cnt = 0;
  int chk_cnt  = 0;

  // Reference model for dut (L/D configuration).
  int m_wr[CH], m_rd[CH], m_cnt[CH], m_adv[CH], m_rpt[CH], m_drop[CH];

  // Drive one clock of stimulus to dut and advance the model; returns at posedge+1.
  task automatic cycle(input logic r, input logic [CH-1:0] e, input logic [CH-1:0] w,
                       input logic [CH-1:0] rr);
    int nrd;
    rst = r; en = e; wr_fs = w; rd_fs = rr;
    @(posedge clk);
    for (int k = 0; k < CH; k++) begin
      if (r) begin
        m_wr[k] = 0; m_rd[k] = 0; m_cnt[k] = 0; m_adv[k] = 0; m_rpt[k] = 0; m_drop[k] = 0;
      end else if (e[k]) begin
        if (w[k]) begin
          m_wr[k] = (m_wr[k] + 1) % L;
          if (m_cnt[k] < 255) m_cnt[k]++;
          m_adv[k]++;
        end
        if (rr[k]) begin
          nrd = (m_wr[k] + L - D) % L;
          if (nrd == m_rd[k] && m_rpt[k] < 65535) m_rpt[k]++;
          if (m_adv[k] >= 2 && m_drop[k] < 65535) m_drop[k]++;
          m_adv[k] = 0;
          m_rd[k]  = nrd;
        end
      end
    end
    #1;
    rst = 1'b0; wr_fs = '0; rd_fs = '0;
  endtask

  task automatic test_reset();
    cycle(1'b1, '0, '0, '0);
    cycle(1'b1, '0, '0, '0);
    for (int k = 0; k < CH; k++) begin
      chk_cnt++;
      if (wr_bufn[8*k +: 8] !== 8'd0)
        $display("FAIL reset_wr ch%0d: got %0d want 0", k, wr_bufn[8*k +: 8]);
      else pass_cnt++;
      chk_cnt++;
      if (rd_bufn[8*k +: 8] !== 8'd0)
        $display("FAIL reset_rd ch%0d: got %0d want 0", k, rd_bufn[8*k +: 8]);
      else pass_cnt++;
      chk_cnt++;
      if (rd_valid[k] !== 1'b0)
        $display("FAIL reset_valid ch%0d: got %b want 0", k, rd_valid[k]);
      else pass_cnt++;
    end
  endtask

  task automatic test_wr_seq();
    int exp_wr[4] = '{1, 2, 0, 1};
    logic exp_v[4] = '{1'b0, 1'b1, 1'b1, 1'b1};
    for (int i = 0; i < 4; i++) begin
      cycle(1'b0, '1, 4'b0001, '0);
      chk_cnt++;
      if (wr_bufn[7:0] !== 8'(exp_wr[i]))
        $display("FAIL wr_seq[%0d]: got %0d want %0d", i, wr_bufn[7:0], exp_wr[i]);
      else pass_cnt++;
      chk_cnt++;
      if (rd_valid[0] !== exp_v[i])
        $display("FAIL wr_valid[%0d]: got %b want %b", i, rd_valid[0], exp_v[i]);
      else pass_cnt++;
    end
  endtask

  task automatic test_map_l4d2();
    int w;
    int exp_rd;
    en2 = '1;
    for (int i = 0; i < 4; i++) begin
      wr2 = 2'b01;
      @(posedge clk); #1;
      wr2 = '0;
      rd2 = 2'b01;
      @(posedge clk); #1;
      rd2 = '0;
      w = (i + 1) % L2;
      exp_rd = (w + L2 - D2) % L2;
      chk_cnt++;
      if (rd_bufn2[7:0] !== 8'(exp_rd) || wr_bufn2[7:0] !== 8'(w))
        $display("FAIL map_l4d2[%0d]: got rd=%0d wr=%0d want rd=%0d wr=%0d", i,
                 rd_bufn2[7:0], wr_bufn2[7:0], exp_rd, w);
      else pass_cnt++;
    end
  endtask

  task automatic test_coincident();
    cycle(1'b0, '1, 4'b0100, '0);
    cycle(1'b0, '1, 4'b0100, 4'b0100);
    chk_cnt++;
    if (wr_bufn[23:16] !== 8'd2)
      $display("FAIL coinc_wr: got %0d want 2", wr_bufn[23:16]);
    else pass_cnt++;
    chk_cnt++;
    if (rd_bufn[23:16] !== 8'd1)
      $display("FAIL coinc_rd: got %0d want 1", rd_bufn[23:16]);
    else pass_cnt++;
  endtask

  task automatic test_ch_disable();
    cycle(1'b1, '0, '0, '0);
    for (int i = 0; i < 5; i++) cycle(1'b0, 4'b1101, 4'b0010, 4'b0010);
    cycle(1'b0, 4'b1101, 4'b0001, '0);
    chk_cnt++;
    if (wr_bufn[15:8] !== 8'd0 || rd_bufn[15:8] !== 8'd0 || rd_valid[1] !== 1'b0)
      $display("FAIL dis_ch1: got wr=%0d rd=%0d v=%b want 0 0 0", wr_bufn[15:8],
               rd_bufn[15:8], rd_valid[1]);
    else pass_cnt++;
    chk_cnt++;
    if (wr_bufn[7:0] !== 8'd1)
      $display("FAIL dis_ch0: got %0d want 1", wr_bufn[7:0]);
    else pass_cnt++;
    cycle(1'b0, '1, 4'b0010, '0);
    chk_cnt++;
    if (wr_bufn[15:8] !== 8'd1)
      $display("FAIL reen_ch1: got %0d want 1", wr_bufn[15:8]);
    else pass_cnt++;
  endtask

  task automatic test_reset_mid();
    cycle(1'b1, '0, '0, '0);
    cycle(1'b0, '1, 4'b0001, 4'b0001);
    cycle(1'b0, '1, 4'b0001, 4'b0001);
    chk_cnt++;
    if (wr_bufn[7:0] !== 8'd2)
      $display("FAIL pre_rst_wr: got %0d want 2", wr_bufn[7:0]);
    else pass_cnt++;
    cycle(1'b1, '1, '1, '1);
    chk_cnt++;
    if (wr_bufn !== '0 || rd_bufn !== '0 || rd_valid !== '0)
      $display("FAIL rst_mid: got wr=%h rd=%h v=%b want 0", wr_bufn, rd_bufn, rd_valid);
    else pass_cnt++;
  endtask

`ifdef UIVBUF_STAT_EN
  task automatic test_stats();
    cycle(1'b1, '0, '0, '0);
    for (int i = 0; i < 3; i++) cycle(1'b0, '1, 4'b0001, '0);
    cycle(1'b0, '1, '0, 4'b0001);
    cycle(1'b0, '1, '0, 4'b0001);
    cycle(1'b0, '1, '0, 4'b0001);
    chk_cnt++;
    if (drop_cnt[15:0] !== 16'd1)
      $display("FAIL stat_drop: got %0d want 1", drop_cnt[15:0]);
    else pass_cnt++;
    chk_cnt++;
    if (rpt_cnt[15:0] !== 16'd2)
      $display("FAIL stat_rpt: got %0d want 2", rpt_cnt[15:0]);
    else pass_cnt++;
  endtask
`endif

  task automatic test_random();
    logic            r;
    logic [CH-1:0]   e, w, rr;
    for (int n = 0; n < 400; n++) begin
      r  = ($urandom_range(0, 99) == 0);
      e  = 4'($urandom) | 4'($urandom);
      w  = 4'($urandom);
      rr = 4'($urandom);
      cycle(r, e, w, rr);
      for (int k = 0; k < CH; k++) begin
        chk_cnt++;
        if (wr_bufn[8*k +: 8] !== 8'(m_wr[k]) || rd_bufn[8*k +: 8] !== 8'(m_rd[k]) ||
            rd_valid[k] !== (m_cnt[k] > D))
          $display("FAIL rand[%0d] ch%0d: got wr=%0d rd=%0d v=%b want wr=%0d rd=%0d v=%b",
                   n, k, wr_bufn[8*k +: 8], rd_bufn[8*k +: 8], rd_valid[k],
                   m_wr[k], m_rd[k], (m_cnt[k] > D));
        else pass_cnt++;
`ifdef UIVBUF_STAT_EN
        chk_cnt++;
        if (rpt_cnt[16*k +: 16] !== 16'(m_rpt[k]) || drop_cnt[16*k +: 16] !== 16'(m_drop[k]))
          $display("FAIL rand_stat[%0d] ch%0d: got rpt=%0d drop=%0d want rpt=%0d drop=%0d",
                   n, k, rpt_cnt[16*k +: 16], drop_cnt[16*k +: 16], m_rpt[k], m_drop[k]);
        else pass_cnt++;
`endif
      end
    end
  endtask

  initial begin
    for (int k = 0; k < CH; k++) begin
      m_wr[k] = 0; m_rd[k] = 0; m_cnt[k] = 0; m_adv[k] = 0; m_rpt[k] = 0; m_drop[k] = 0;
    end
    @(posedge clk); #1;
    test_reset();
    test_wr_seq();
    test_map_l4d2();
    test_coincident();
    test_ch_disable();
    test_reset_mid();
`ifdef UIVBUF_STAT_EN
    test_stats();
`endif
    test_random();
    $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
    $finish;
  end

endmodule
